// File: rtl/gba_intro_pkg.sv
// Shared constants and state encoding for the GBA black-and-white intro image path.
// The image is stored as 1600 bytes across three 512-byte banks and one 64-byte bank.
package gba_intro_pkg;

  localparam int IMG_W           = 160;
  localparam int IMG_H           = 80;
  localparam int BANK_BYTES      = 512;
  localparam int LAST_BANK_BYTES = 64;
  localparam int TOTAL_BYTES     = 3 * BANK_BYTES + LAST_BANK_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gba_bw_byte_serializer.sv
// Turns returned image bytes into an MSB-first 1-bit pixel stream.
// It holds one byte in the shift register and one more in the prefetch buffer.
module gba_bw_byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load_valid,
  input  logic [7:0] i_load_data,
  input  logic       i_pix_ready,
  output logic       o_pix_valid,
  output logic       o_pix_data,
  output logic       o_buf_empty,
  output logic       o_last_take,
  output logic       o_take
);

  logic [7:0] r_sr;
  logic [7:0] r_buf;
  logic [3:0] r_cnt;
  logic       r_buf_full;
  logic       r_valid;

  logic [7:0] w_sr_n;
  logic [7:0] w_buf_n;
  logic [3:0] w_cnt_n;
  logic       w_buf_full_n;
  logic       w_take;
  logic       w_sr_free;

  assign w_take    = r_valid && i_pix_ready;
  assign w_sr_free = (r_cnt == 4'd0) || ((r_cnt == 4'd1) && w_take);

  // A buffered byte always moves ahead of a byte arriving in the same cycle.
  always_comb begin
    w_sr_n       = r_sr;
    w_buf_n      = r_buf;
    w_cnt_n      = r_cnt;
    w_buf_full_n = r_buf_full;
    if (w_sr_free) begin
      if (r_buf_full) begin
        w_sr_n       = r_buf;
        w_cnt_n      = 4'd8;
        w_buf_full_n = i_load_valid;
        if (i_load_valid) w_buf_n = i_load_data;
      end else if (i_load_valid) begin
        w_sr_n  = i_load_data;
        w_cnt_n = 4'd8;
      end else begin
        w_cnt_n = 4'd0;
      end
    end else begin
      if (w_take) begin
        w_sr_n  = {r_sr[6:0], 1'b0};
        w_cnt_n = r_cnt - 4'd1;
      end
      if (i_load_valid) begin
        w_buf_n      = i_load_data;
        w_buf_full_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= 8'd0;
      r_buf      <= 8'd0;
      r_cnt      <= 4'd0;
      r_buf_full <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sr       <= w_sr_n;
      r_buf      <= w_buf_n;
      r_cnt      <= w_cnt_n;
      r_buf_full <= w_buf_full_n;
      r_valid    <= (w_cnt_n != 4'd0);
    end
  end

  assign o_pix_valid = r_valid;
  assign o_pix_data  = r_sr[7];
  assign o_buf_empty = !r_buf_full;
  assign o_last_take = (r_cnt == 4'd1) && w_take;
  assign o_take      = w_take;

endmodule

// File: rtl/gba_bw_pixel_streamer.sv
// Walks the four intro block RAMs in bank order and streams the 160x80 1-bit raster.
// Holds the frame FSM, the single-outstanding-read fetch engine and the x/y raster counters.
module gba_bw_pixel_streamer
  import gba_intro_pkg::*;
#(
  parameter int IMG_W           = gba_intro_pkg::IMG_W,
  parameter int IMG_H           = gba_intro_pkg::IMG_H,
  parameter int BANK_BYTES      = gba_intro_pkg::BANK_BYTES,
  parameter int LAST_BANK_BYTES = gba_intro_pkg::LAST_BANK_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic [3:0]  o_rd_en,
  output logic [8:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic [3:0]  i_rd_valid,
  output logic        o_pix_valid,
  input  logic        i_pix_ready,
  output logic        o_pix_data,
  output logic [7:0]  o_pix_x,
  output logic [6:0]  o_pix_y,
  output logic        o_pix_sof,
  output logic        o_pix_eol,
  output logic        o_frame_done,
  output logic [1:0]  o_dbg_state
);

  localparam int TOTAL = 3 * BANK_BYTES + LAST_BANK_BYTES;

  state_t      r_state, w_state_n;
  logic        r_busy, r_done, r_sof, r_eol;
  logic [3:0]  r_rd_en;
  logic [8:0]  r_rd_addr;
  logic        r_pend;
  logic [1:0]  r_pend_bank;
  logic [1:0]  r_fbank;
  logic [8:0]  r_faddr;
  logic [10:0] r_issued;
  logic [7:0]  r_x;
  logic [6:0]  r_y;

  logic       w_accept, w_last_hs, w_issue, w_ret;
  logic [7:0] w_ret_data;
  logic       w_buf_empty, w_last_take, w_take;

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_last_hs = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_state_n = ST_RUN;
        w_accept  = 1'b1;
      end
      ST_RUN: if (w_take && (r_x == 8'(IMG_W - 1)) && (r_y == 7'(IMG_H - 1))) begin
        w_state_n = ST_DONE;
        w_last_hs = 1'b1;
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // The next read goes out only when its byte has somewhere to land on return.
  assign w_issue = ((r_state == ST_RUN) || w_accept) && !r_pend &&
                   (r_issued != 11'(TOTAL)) && (w_buf_empty || w_last_take);
  assign w_ret      = r_pend && i_rd_valid[r_pend_bank];
  assign w_ret_data = i_rd_data[{r_pend_bank, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 4'd0;
      r_rd_addr   <= 9'd0;
      r_pend      <= 1'b0;
      r_pend_bank <= 2'd0;
      r_fbank     <= 2'd0;
      r_faddr     <= 9'd0;
      r_issued    <= 11'd0;
    end else begin
      r_state <= w_state_n;
      r_done  <= w_last_hs;
      if (w_accept) r_busy <= 1'b1;
      else if (w_last_hs) r_busy <= 1'b0;
      r_rd_en <= w_issue ? (4'b0001 << r_fbank) : 4'd0;
      if (w_issue) begin
        r_rd_addr   <= r_faddr;
        r_pend_bank <= r_fbank;
        r_pend      <= 1'b1;
        r_issued    <= r_issued + 11'd1;
        if (r_faddr == 9'(BANK_BYTES - 1)) begin
          r_faddr <= 9'd0;
          r_fbank <= r_fbank + 2'd1;
        end else begin
          r_faddr <= r_faddr + 9'd1;
        end
      end else if (w_ret) begin
        r_pend <= 1'b0;
      end
      if (r_state == ST_DONE) begin
        r_fbank  <= 2'd0;
        r_faddr  <= 9'd0;
        r_issued <= 11'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= 8'd0;
      r_y   <= 7'd0;
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end else begin
      if (w_accept) r_sof <= 1'b1;
      else if (w_take) r_sof <= 1'b0;
      if (w_take) begin
        r_eol <= (r_x == 8'(IMG_W - 2));
        if (r_x == 8'(IMG_W - 1)) begin
          r_x <= 8'd0;
          r_y <= (r_y == 7'(IMG_H - 1)) ? 7'd0 : r_y + 7'd1;
        end else begin
          r_x <= r_x + 8'd1;
        end
      end
    end
  end

  gba_bw_byte_serializer u_ser (
    .clk          (clk),
    .rst          (rst),
    .i_load_valid (w_ret),
    .i_load_data  (w_ret_data),
    .i_pix_ready  (i_pix_ready),
    .o_pix_valid  (o_pix_valid),
    .o_pix_data   (o_pix_data),
    .o_buf_empty  (w_buf_empty),
    .o_last_take  (w_last_take),
    .o_take       (w_take)
  );

  assign o_busy       = r_busy;
  assign o_rd_en      = r_rd_en;
  assign o_rd_addr    = r_rd_addr;
  assign o_pix_x      = r_x;
  assign o_pix_y      = r_y;
  assign o_pix_sof    = r_sof;
  assign o_pix_eol    = r_eol;
  assign o_frame_done = r_done;
  assign o_dbg_state  = r_state;

endmodule
